hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences the ID/EX pipeline register and the IF/ID/PC write enables.
- Keeps a 3-entry scoreboard of in-flight destination registers for the EX, MEM and WB stages.
- Raises a stall and inserts a bubble into ID/EX on read-after-write hazards, and flushes on taken branches.
- Sits beside the decoder; its outputs drive PC write-enable, IF/ID write-enable/flush and the ID/EX bubble (all ID/EX control bits forced to 0).

Parameters:
- REGFILE_WRITE_THROUGH, 1: 1 = register file forwards same-cycle WB writes to ID reads, so the WB entry is not compared; 0 = the WB entry is also compared.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  5  source register A
- id_rt_addr  in  5  source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_ifWriteRegsFile  in  1  instruction writes the register file
- id_registerWriteAddress  in  5  destination register
- id_isLoad  in  1  write-back data comes from memory
- ex_branchTaken  in  1  branch resolved taken in EX
- id_shouldStall  out  1  hazard stall (combinational)
- pc_write_en  out  1  = ~id_shouldStall
- if_id_write_en  out  1  = ~id_shouldStall
- if_id_flush  out  1  = ex_branchTaken
- id_ex_bubble  out  1  = id_shouldStall | ex_branchTaken | ~id_valid
- ex_fwd_rs_sel  out  2  registered forward select, A input
- ex_fwd_rt_sel  out  2  registered forward select, B input
- stall_count  out  CNT_W  cycles with id_shouldStall=1, saturating
- flush_count  out  CNT_W  cycles with ex_branchTaken=1, saturating

Behaviour:
- Scoreboard: one entry per stage, each {valid, waddr[4:0], load}.
- Entries advance every clock: WB<=MEM, MEM<=EX.
- EX loads the ID entry {id_valid & id_ifWriteRegsFile, id_registerWriteAddress, id_isLoad} when id_ex_bubble=0; otherwise EX loads an invalid entry.
- Match(stage, r) = entry.valid & (entry.waddr == r) & (r != 0) & the matching use bit. Register 0 never causes a hazard.
- Without FORWARDING_EN: id_shouldStall = ~ex_branchTaken & id_valid & (match on EX | match on MEM | (match on WB if REGFILE_WRITE_THROUGH==0)).
- Flush priority: ex_branchTaken forces id_shouldStall=0 in the same cycle; the flush wins over the stall.
- A stall holds PC and IF/ID and bubbles ID/EX; the hazard re-evaluates every cycle until the producer retires.
- Latency: stall, enables and bubble are combinational from ID inputs plus scoreboard flops. Forward selects and counters update on the clock edge.
- Forward selects: 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB result. Without FORWARDING_EN they stay 00.
- Counters saturate at all-ones and do not wrap.
- Reset (rst=0 at a clock edge): all scoreboard entries invalid, ex_fwd_*_sel=00, counters=0. Combinational outputs then follow from these reset values: id_shouldStall=0, enables=1 (when no flush).
- Reset asserted mid-stall: the stall drops the cycle after the reset edge.
- ID inputs are ignored while rst=0.

Optional Feature:
- Macro FORWARDING_EN.
- Defined:
  - Stall only on load-use: the EX entry is a load and matches.
  - At each edge where ID/EX loads a non-bubble, ex_fwd_*_sel is captured from that operand's match against the current scoreboard:
    - EX non-load match -> 01
    - else MEM match (load or not) -> 10
    - else -> 00
    - EX takes priority over MEM.
  - On a bubble, the selects capture 00.
- Undefined: full stall behaviour described above, and the selects are tied to 00.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 -> id_shouldStall=0, pc_write_en=1, stall_count=0, selects=00.
- RAW stall (no FORWARDING_EN): write r5 into EX, then ID reads rs=5 -> stall held 2 cycles (EX, then MEM), released the 3rd cycle; stall_count=2; 2 bubbles inserted.
- r0 and flush: ID reads r0 while r0 is in flight -> no stall. Set ex_branchTaken=1 during an active stall -> id_shouldStall=0, if_id_flush=1, id_ex_bubble=1, flush_count=1.
- REGFILE_WRITE_THROUGH=0: r7 producer reaches WB while ID reads rt=7 -> exactly 3 stall cycles.
- FORWARDING_EN: ALU writes r3, next instruction reads rs=3 -> no stall, ex_fwd_rs_sel=01. A load to r4 followed by a reader of r4 -> 1 stall, then ex_fwd_rt_sel=10.
- Counter saturation with CNT_W=4: 20 continuous stall cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ----------------------------------------------------------------------------
// hazard_stall_controller
//
// Purpose:
//   Read-after-write hazard detection and pipeline sequencing beside the
//   decoder. A 3-entry scoreboard tracks the destination registers in flight
//   in EX, MEM and WB. On a hazard the controller holds PC and IF/ID and
//   inserts a bubble into ID/EX. A taken branch in EX flushes IF/ID and
//   bubbles ID/EX, and it overrides any stall in the same cycle.
//
// Build option:
//   FORWARDING_EN  When defined, only load-use hazards stall. Registered
//                  forward selects steer the EX operand muxes. When not
//                  defined, every in-window RAW match stalls and the selects
//                  stay 00.
//
// Parameters:
//   REGFILE_WRITE_THROUGH  1: the register file bypasses a same-cycle WB
//                          write to ID reads, so the WB entry is ignored.
//                          0: the WB entry is also compared.
//   CNT_W                  Width of the saturating performance counters.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous reset, active low
//   id_valid                 ID holds a real instruction
//   id_rs_addr/id_rt_addr    source register addresses
//   id_uses_rs/id_uses_rt    instruction reads rs / rt
//   id_ifWriteRegsFile       instruction writes the register file
//   id_registerWriteAddress  destination register
//   id_isLoad                write-back data comes from memory
//   ex_branchTaken           branch resolved taken in EX
//   id_shouldStall           hazard stall (combinational)
//   pc_write_en              PC write enable
//   if_id_write_en           IF/ID write enable
//   if_id_flush              IF/ID flush
//   id_ex_bubble             force all ID/EX control bits to 0
//   ex_fwd_rs_sel            forward select for A: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   ex_fwd_rt_sel            forward select for B, same encoding
//   stall_count              saturating count of stall cycles
//   flush_count              saturating count of taken-branch cycles
// ----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter bit REGFILE_WRITE_THROUGH = 1'b1,
    parameter int CNT_W                 = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_ifWriteRegsFile,
    input  logic [4:0]       id_registerWriteAddress,
    input  logic             id_isLoad,
    input  logic             ex_branchTaken,
    output logic             id_shouldStall,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       ex_fwd_rs_sel,
    output logic [1:0]       ex_fwd_rt_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] waddr;
        logic       load;
    } sb_entry_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;

    logic [1:0]       rs_sel_q, rs_sel_d;
    logic [1:0]       rt_sel_q, rt_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;
    logic hazard;
    logic stall;
    logic bubble;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r,
                                    input logic use_bit);
        return e.valid & (e.waddr == r) & (r != 5'd0) & use_bit;
    endfunction

    always_comb begin
        rs_ex  = sb_hit(ex_q,  id_rs_addr, id_uses_rs);
        rs_mem = sb_hit(mem_q, id_rs_addr, id_uses_rs);
        rs_wb  = sb_hit(wb_q,  id_rs_addr, id_uses_rs);
        rt_ex  = sb_hit(ex_q,  id_rt_addr, id_uses_rt);
        rt_mem = sb_hit(mem_q, id_rt_addr, id_uses_rt);
        rt_wb  = sb_hit(wb_q,  id_rt_addr, id_uses_rt);
    end

`ifdef FORWARDING_EN
    // A load result is not available until after MEM, so a reader directly
    // behind a load must wait one cycle. Every other case is forwarded.
    assign hazard = ex_q.load & (rs_ex | rt_ex);
`else
    assign hazard = rs_ex | rt_ex | rs_mem | rt_mem |
                    (~REGFILE_WRITE_THROUGH & (rs_wb | rt_wb));
`endif

    // A taken branch discards the ID instruction, so its hazard is irrelevant.
    assign stall  = ~ex_branchTaken & id_valid & hazard;
    assign bubble = stall | ex_branchTaken | ~id_valid;

    assign id_shouldStall = stall;
    assign pc_write_en    = ~stall;
    assign if_id_write_en = ~stall;
    assign if_id_flush    = ex_branchTaken;
    assign id_ex_bubble   = bubble;

    // A bubble enters EX as an invalid entry so it can never match later.
    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid = id_valid & id_ifWriteRegsFile;
            ex_d.waddr = id_registerWriteAddress;
            ex_d.load  = id_isLoad;
        end
    end

`ifdef FORWARDING_EN
    // The youngest producer wins: EX is newer than MEM. An EX load never
    // reaches this mux because that case stalls and bubbles instead.
    always_comb begin
        rs_sel_d = SEL_RF;
        rt_sel_d = SEL_RF;
        if (!bubble) begin
            if (rs_ex && !ex_q.load) rs_sel_d = SEL_EXM;
            else if (rs_mem)         rs_sel_d = SEL_MWB;
            if (rt_ex && !ex_q.load) rt_sel_d = SEL_EXM;
            else if (rt_mem)         rt_sel_d = SEL_MWB;
        end
    end
`else
    always_comb begin
        rs_sel_d = SEL_RF;
        rt_sel_d = SEL_RF;
    end
`endif

    // Saturating counters: they hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ex_branchTaken && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            rs_sel_q    <= SEL_RF;
            rt_sel_q    <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            rs_sel_q    <= rs_sel_d;
            rt_sel_q    <= rt_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_fwd_rs_sel = rs_sel_q;
    assign ex_fwd_rt_sel = rt_sel_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

    // The load bit of the older stages, and the whole WB entry in some
    // builds, does not affect any output. It is kept so that every stage has
    // the same shape.
    logic sb_unused;
    assign sb_unused = ^{mem_q.load, wb_q, rs_wb, rt_wb};

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr, id_rt_addr, id_registerWriteAddress;
    logic       id_uses_rs, id_uses_rt, id_ifWriteRegsFile, id_isLoad;
    logic       ex_branchTaken;

    // dut_a: write-through register file, 4-bit counters (saturation reachable)
    // dut_b: no write-through (WB entry compared), full-width counters
    logic       a_stall, a_pcw, a_ifw, a_flush, a_bub;
    logic [1:0] a_rs_sel, a_rt_sel;
    logic [3:0] a_scnt, a_fcnt;
    logic       b_stall, b_pcw, b_ifw, b_flush, b_bub;
    logic [1:0] b_rs_sel, b_rt_sel;
    logic [31:0] b_scnt, b_fcnt;

    hazard_stall_controller #(.REGFILE_WRITE_THROUGH(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ifWriteRegsFile(id_ifWriteRegsFile),
        .id_registerWriteAddress(id_registerWriteAddress),
        .id_isLoad(id_isLoad), .ex_branchTaken(ex_branchTaken),
        .id_shouldStall(a_stall), .pc_write_en(a_pcw), .if_id_write_en(a_ifw),
        .if_id_flush(a_flush), .id_ex_bubble(a_bub),
        .ex_fwd_rs_sel(a_rs_sel), .ex_fwd_rt_sel(a_rt_sel),
        .stall_count(a_scnt), .flush_count(a_fcnt)
    );

    hazard_stall_controller #(.REGFILE_WRITE_THROUGH(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ifWriteRegsFile(id_ifWriteRegsFile),
        .id_registerWriteAddress(id_registerWriteAddress),
        .id_isLoad(id_isLoad), .ex_branchTaken(ex_branchTaken),
        .id_shouldStall(b_stall), .pc_write_en(b_pcw), .if_id_write_en(b_ifw),
        .if_id_flush(b_flush), .id_ex_bubble(b_bub),
        .ex_fwd_rs_sel(b_rs_sel), .ex_fwd_rt_sel(b_rt_sel),
        .stall_count(b_scnt), .flush_count(b_fcnt)
    );

    logic        o_stall[2], o_pcw[2], o_ifw[2], o_flush[2], o_bub[2];
    logic [1:0]  o_rs_sel[2], o_rt_sel[2];
    logic [31:0] o_scnt[2], o_fcnt[2];
    assign o_stall[0] = a_stall;  assign o_stall[1] = b_stall;
    assign o_pcw[0]   = a_pcw;    assign o_pcw[1]   = b_pcw;
    assign o_ifw[0]   = a_ifw;    assign o_ifw[1]   = b_ifw;
    assign o_flush[0] = a_flush;  assign o_flush[1] = b_flush;
    assign o_bub[0]   = a_bub;    assign o_bub[1]   = b_bub;
    assign o_rs_sel[0] = a_rs_sel; assign o_rs_sel[1] = b_rs_sel;
    assign o_rt_sel[0] = a_rt_sel; assign o_rt_sel[1] = b_rt_sel;
    assign o_scnt[0] = {28'd0, a_scnt}; assign o_scnt[1] = b_scnt;
    assign o_fcnt[0] = {28'd0, a_fcnt}; assign o_fcnt[1] = b_fcnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per DUT, a list of producers in flight ordered by age
    // (0 = one instruction ahead of ID, 2 = three ahead).
    bit     m_wt[2]   = '{1'b1, 1'b0};
    longint m_max[2]  = '{64'd15, 64'hFFFF_FFFF};
    bit     p_v[2][3];
    int     p_a[2][3];
    bit     p_l[2][3];
    int     m_rs_sel[2], m_rt_sel[2];
    longint m_scnt[2], m_fcnt[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                p_v[d][k] = 1'b0; p_a[d][k] = 0; p_l[d][k] = 1'b0;
            end
            m_rs_sel[d] = 0; m_rt_sel[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
        end
    endtask

    // Age of the most recent in-flight writer of r, or -1 if none matters.
    function automatic int youngest(input int d, input int r, input bit use_bit);
        if (!use_bit || r == 0) return -1;
        for (int k = 0; k < 3; k++)
            if (p_v[d][k] && p_a[d][k] == r) return k;
        return -1;
    endfunction

    task automatic check_and_advance();
        for (int d = 0; d < 2; d++) begin
            int  rs_age, rt_age, sel_rs, sel_rt;
            bit  haz, e_stall, e_bub;
            rs_age = youngest(d, int'(id_rs_addr), id_uses_rs);
            rt_age = youngest(d, int'(id_rt_addr), id_uses_rt);
`ifdef FORWARDING_EN
            haz = (rs_age == 0 || rt_age == 0) && p_l[d][0];
            sel_rs = (rs_age == 0) ? 1 : (rs_age == 1) ? 2 : 0;
            sel_rt = (rt_age == 0) ? 1 : (rt_age == 1) ? 2 : 0;
`else
            begin
                int win;
                win = m_wt[d] ? 2 : 3;
                haz = (rs_age >= 0 && rs_age < win) || (rt_age >= 0 && rt_age < win);
            end
            sel_rs = 0;
            sel_rt = 0;
`endif
            e_stall = !ex_branchTaken && id_valid && haz;
            e_bub   = e_stall || ex_branchTaken || !id_valid;

            chk($sformatf("stall%0d", d),   64'(o_stall[d]), 64'(e_stall));
            chk($sformatf("pcw%0d", d),     64'(o_pcw[d]),   64'(!e_stall));
            chk($sformatf("ifw%0d", d),     64'(o_ifw[d]),   64'(!e_stall));
            chk($sformatf("flush%0d", d),   64'(o_flush[d]), 64'(ex_branchTaken));
            chk($sformatf("bubble%0d", d),  64'(o_bub[d]),   64'(e_bub));
            chk($sformatf("rs_sel%0d", d),  64'(o_rs_sel[d]), 64'(m_rs_sel[d]));
            chk($sformatf("rt_sel%0d", d),  64'(o_rt_sel[d]), 64'(m_rt_sel[d]));
            chk($sformatf("stall_cnt%0d", d), 64'(o_scnt[d]), 64'(m_scnt[d]));
            chk($sformatf("flush_cnt%0d", d), 64'(o_fcnt[d]), 64'(m_fcnt[d]));

            if (!rst) begin
                for (int k = 0; k < 3; k++) p_v[d][k] = 1'b0;
                m_rs_sel[d] = 0; m_rt_sel[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
            end else begin
                for (int k = 2; k > 0; k--) begin
                    p_v[d][k] = p_v[d][k-1]; p_a[d][k] = p_a[d][k-1]; p_l[d][k] = p_l[d][k-1];
                end
                p_v[d][0] = !e_bub && id_valid && id_ifWriteRegsFile;
                p_a[d][0] = int'(id_registerWriteAddress);
                p_l[d][0] = id_isLoad;
                m_rs_sel[d] = e_bub ? 0 : sel_rs;
                m_rt_sel[d] = e_bub ? 0 : sel_rt;
                if (e_stall && m_scnt[d] < m_max[d]) m_scnt[d]++;
                if (ex_branchTaken && m_fcnt[d] < m_max[d]) m_fcnt[d]++;
            end
        end
    endtask

    task automatic run_cycle(input bit r, input bit v, input int rs, input int rt,
                             input bit urs, input bit urt, input bit wr, input int wa,
                             input bit ld, input bit br);
        @(negedge clk);
        rst = r; id_valid = v;
        id_rs_addr = 5'(rs); id_rt_addr = 5'(rt);
        id_uses_rs = urs; id_uses_rt = urt;
        id_ifWriteRegsFile = wr; id_registerWriteAddress = 5'(wa);
        id_isLoad = ld; ex_branchTaken = br;
        #1;
        check_and_advance();
    endtask

    function automatic int pick_reg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                           : int'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b0; id_valid = 1'b1; id_rs_addr = 5'd5; id_rt_addr = 5'd5;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_ifWriteRegsFile = 1'b1;
        id_registerWriteAddress = 5'd5; id_isLoad = 1'b0; ex_branchTaken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // reset held with a valid, hazard-looking instruction in ID
        repeat (2) run_cycle(0, 1, 5, 5, 1, 1, 1, 5, 0, 0);
        // ALU producer r5, then a reader of rs=5 held in ID
        run_cycle(1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        repeat (4) run_cycle(1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        // r0 in flight never causes a hazard
        run_cycle(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) run_cycle(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        // branch taken during an active stall
        run_cycle(1, 1, 0, 0, 0, 0, 1, 6, 0, 0);
        run_cycle(1, 1, 6, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 6, 0, 1, 0, 0, 0, 0, 1);
        run_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // r7 producer reaching WB while ID reads rt=7
        run_cycle(1, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        repeat (5) run_cycle(1, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        // load to r4 followed by a reader of r4
        run_cycle(1, 1, 0, 0, 0, 0, 1, 4, 1, 0);
        repeat (4) run_cycle(1, 1, 0, 4, 0, 1, 1, 9, 0, 0);
        // reset arriving mid-stall
        run_cycle(1, 1, 0, 0, 0, 0, 1, 8, 0, 0);
        run_cycle(1, 1, 8, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(0, 1, 8, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 8, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 399) != 0),
                      ($urandom_range(0, 9) != 0),
                      pick_reg(), pick_reg(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), pick_reg(),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
